// File: rtl/ex_muldiv_unit.sv
// Iterative RV32M multiply/divide unit for the EX stage: one shift-add or
// restoring-subtract step per cycle, stalling the front end until the result is ready.
module ex_muldiv_unit #(
  parameter int XLEN     = 32,
  parameter bit FAST_DIV = 1'b1
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_flush,
  input  logic            i_ex_stall,
  input  logic [31:0]     i_inst,
  input  logic [XLEN-1:0] i_rs1_val,
  input  logic [XLEN-1:0] i_rs2_val,
  output logic            o_is_mdu,
  output logic            o_busy,
  output logic            o_done,
  output logic [XLEN-1:0] o_result
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e              state_q, state_d;
  logic [CW-1:0]       count_q, count_d;
  logic [2:0]          f3_q, f3_d;
  logic                neg_q, neg_d, rneg_q, rneg_d;
  logic [XLEN-1:0]     opnd_q, opnd_d;
  logic [XLEN-1:0]     result_q, result_d;
  logic [2*XLEN-1:0]   prod_q, prod_d;

  logic [2:0]          f3;
  logic                start, a_signed, b_signed, sign_a, sign_b;
  logic                div_zero, div_ovf, fast;
  logic [XLEN-1:0]     a_mag, b_mag, fast_res;
  logic [XLEN:0]       mul_sum;
  logic [XLEN+1:0]     diff;
  logic                q_bit;
  logic [2*XLEN-1:0]   mul_next, div_next, step_next;
  logic                unused_bits;

  function automatic logic [XLEN-1:0] finish_res(input logic [2:0]        op,
                                                 input logic              neg,
                                                 input logic              rneg,
                                                 input logic [2*XLEN-1:0] p);
    logic [2*XLEN-1:0] ps;
    logic [XLEN-1:0]   lo, hi;
    ps = neg ? -p : p;
    lo = p[XLEN-1:0];
    hi = p[2*XLEN-1:XLEN];
    if (!op[2])      finish_res = (op[1:0] == 2'b00) ? ps[XLEN-1:0] : ps[2*XLEN-1:XLEN];
    else if (!op[1]) finish_res = neg ? -lo : lo;
    else             finish_res = rneg ? -hi : hi;
  endfunction

  // Decode and operand conditioning
  assign f3       = i_inst[14:12];
  assign o_is_mdu = (i_inst[6:0] == 7'b0110011) && (i_inst[31:25] == 7'b0000001);
  assign start    = o_is_mdu && !i_flush;
  assign a_signed = (f3 == 3'b001) || (f3 == 3'b010) || (f3 == 3'b100) || (f3 == 3'b110);
  assign b_signed = (f3 == 3'b001) || (f3 == 3'b100) || (f3 == 3'b110);
  assign sign_a   = a_signed && i_rs1_val[XLEN-1];
  assign sign_b   = b_signed && i_rs2_val[XLEN-1];
  assign a_mag    = sign_a ? -i_rs1_val : i_rs1_val;
  assign b_mag    = sign_b ? -i_rs2_val : i_rs2_val;
  assign div_zero = f3[2] && (i_rs2_val == '0);
  assign div_ovf  = f3[2] && !f3[0] && (i_rs1_val == {1'b1, {(XLEN-1){1'b0}}}) && (&i_rs2_val);
  assign fast     = FAST_DIV && (div_zero || div_ovf);

  always_comb begin
    fast_res = '0;
    if (div_zero) fast_res = f3[1] ? i_rs1_val : '1;
    else          fast_res = f3[1] ? '0 : i_rs1_val;
  end

  // Iteration step: prod_q holds {acc, multiplier} for mul, {remainder, dividend/quotient} for div
  assign mul_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, prod_q[XLEN-1:1]};
  assign diff     = {1'b0, prod_q[2*XLEN-1:XLEN], prod_q[XLEN-1]} - {2'b00, opnd_q};
  assign q_bit    = !diff[XLEN+1];
  assign div_next = {q_bit ? diff[XLEN-1:0] : {prod_q[2*XLEN-2:XLEN], prod_q[XLEN-1]},
                     prod_q[XLEN-2:0], q_bit};
  assign step_next = f3_q[2] ? div_next : mul_next;
  assign unused_bits = ^{i_inst[24:15], i_inst[11:7], diff[XLEN]};

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    f3_d     = f3_q;
    neg_d    = neg_q;
    rneg_d   = rneg_q;
    opnd_d   = opnd_q;
    prod_d   = prod_q;
    result_d = result_q;
    o_busy   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          o_busy  = 1'b1;
          f3_d    = f3;
          count_d = '0;
          rneg_d  = sign_a;
          // A zero divisor keeps the all-ones quotient regardless of dividend sign
          neg_d   = (sign_a ^ sign_b) && !div_zero;
          if (fast) begin
            state_d  = DONE;
            result_d = fast_res;
          end else begin
            state_d = BUSY;
            opnd_d  = f3[2] ? b_mag : a_mag;
            prod_d  = {{XLEN{1'b0}}, f3[2] ? a_mag : b_mag};
          end
        end
      end
      BUSY: begin
        o_busy  = 1'b1;
        prod_d  = step_next;
        count_d = count_q + CW'(1);
        if (count_q == CW'(XLEN-1)) begin
          state_d  = DONE;
          result_d = finish_res(f3_q, neg_q, rneg_q, step_next);
        end
      end
      DONE: begin
        if (!i_ex_stall) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (i_flush) begin
      state_d  = IDLE;
      o_busy   = 1'b0;
      result_d = result_q;
    end
  end

  // Control and result registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= IDLE;
      count_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      result_q <= result_d;
    end
  end

  // Datapath registers
  always_ff @(posedge i_clk) begin
    f3_q   <= f3_d;
    neg_q  <= neg_d;
    rneg_q <= rneg_d;
    opnd_q <= opnd_d;
    prod_q <= prod_d;
  end

  assign o_done   = (state_q == DONE);
  assign o_result = result_q;

endmodule
